cartpole_episode_driver: RTL
============================

// Module: cartpole_episode_driver
// PURPOSE
//  Agent-side counterpart of the CartPole step-compute core: owns the current state, issues one step per policy action.
//  Drives the core's enable/state/action inputs, consumes its next-state/reward/done/valid outputs and auto-resets on episode end.
//  Sits between the policy (action handshake) and one step-compute core; reports per-episode length and return.
// PARAMETERS
//  STA_WL    128   state width, {x, x_dot, theta, theta_dot}, 4 x FP32, x in [127:96]
//  ACT_WL    1     action width
//  RWD_WL    1     per-step reward width, unsigned
//  STEP_WL   16    episode step counter width
//  RET_WL    16    episode return accumulator width
//  MAX_STEPS 500   truncation limit, steps per episode, 1..2^STEP_WL-1
//  TIMEOUT   1024  max cycles to wait for core valid before error
//  INIT_STA  {32'hBDDA4B6F,32'hBE7002B9,32'h3E53E72E,32'h3F5F1AFC}  state loaded at start of every episode
// PORTS
//  i_clk        in   1        clock, all logic on rising edge
//  i_rst        in   1        asynchronous reset, active-high
//  i_run        in   1        level; high = keep running episodes, low = stop after current episode
//  o_obs        out  STA_WL   current state presented to policy
//  o_act_ready  out  1        high while waiting for an action (obs valid)
//  i_act_valid  in   1        policy action valid
//  i_act        in   ACT_WL   policy action
//  o_env_ena    out  1        one-cycle step request to core
//  o_env_sta    out  STA_WL   state to core, stable from ena until valid
//  o_env_act    out  ACT_WL   action to core, stable from ena until valid
//  i_env_sta    in   STA_WL   next state from core
//  i_env_rwd    in   RWD_WL   step reward from core
//  i_env_done   in   1        terminal flag from core
//  i_env_valid  in   1        core outputs valid, one-cycle qualifier
//  o_ep_valid   out  1        one-cycle pulse: episode summary valid
//  o_ep_len     out  STEP_WL  steps in finished episode
//  o_ep_ret     out  RET_WL   summed reward of finished episode
//  o_ep_trunc   out  1        1 = ended by MAX_STEPS, 0 = ended by core done
//  o_busy       out  1        high in any state except IDLE
//  o_err        out  1        sticky: core timeout
// BEHAVIOUR
//  Reset: all outputs 0; state reg = INIT_STA; counters 0; FSM IDLE. Reset mid-step abandons the step, no summary emitted.
//  FSM: IDLE -> OBS when i_run=1, clears o_err, state=INIT_STA, step=0, ret=0.
//   OBS: o_act_ready=1; i_act_valid&o_act_ready latches action -> ISSUE next cycle.
//   ISSUE: o_env_ena=1 exactly one cycle -> WAIT.
//   WAIT: on i_env_valid latch state<=i_env_sta, step+=1, ret+=zext(i_env_rwd) -> CHECK; i_env_valid outside WAIT ignored.
//   WAIT timeout: TIMEOUT cycles without valid -> o_err=1, IDLE, no summary.
//   CHECK: done or step==MAX_STEPS -> REPORT; else -> OBS.
//   REPORT: o_ep_valid=1 one cycle with len/ret/trunc; state<=INIT_STA, counters cleared; -> OBS if i_run else IDLE.
//  Latency: action accept -> ena 1 cycle; valid -> next o_act_ready 2 cycles (CHECK, OBS); valid -> o_ep_valid 2 cycles.
//  Done and step==MAX_STEPS same step: o_ep_trunc=0 (termination wins).
//  ret saturates at all-ones of RET_WL; step never exceeds MAX_STEPS.
//  o_ep_len/o_ep_ret/o_ep_trunc hold last summary until next REPORT.
//  i_run low mid-episode: episode continues to completion, then IDLE.
//  o_obs = state reg at all times; o_env_sta = state reg, o_env_act = latched action.
// STRUCTURE
//  Shared header cartpole_defs.vh: STA_WL, ACT_WL, RWD_WL, field offsets (X/X_DOT/THETA/THETA_DOT), INIT_STA, FSM encodings.
//  One sub-module: cartpole_ep_stats: step counter, saturating return accumulator, limit compare, clear/inc controls.
//  FSM, state register and core handshake stay in top.
// TESTING
//  Reset then i_run=1 -> o_obs=INIT_STA, o_act_ready=1 next cycle, all other outputs 0.
//  Act=1, core model valid after 3 cycles, rwd=1, done=0 -> single ena pulse, o_obs=returned state, ready 2 cycles later.
//  Core done on step 7, rwd=1 each -> o_ep_valid pulse, len=7, ret=7, trunc=0, o_obs=INIT_STA.
//  MAX_STEPS=4, done never -> len=4, ret=4, trunc=1; done on step 4 -> trunc=0.
//  Core never valid -> after TIMEOUT cycles o_err=1, o_busy=0; i_run=1 again clears o_err.
//  Assert i_rst in WAIT, spurious i_env_valid in OBS -> outputs 0, no ep_valid; spurious valid ignored.

Source files
------------

// File: rtl/cartpole_episode_driver_pkg.sv
// Shared constants, default widths and FSM state type for the CartPole episode driver.
package cartpole_episode_driver_pkg;

  localparam int CP_STA_WL    = 128;
  localparam int CP_ACT_WL    = 1;
  localparam int CP_RWD_WL    = 1;
  localparam int CP_STEP_WL   = 16;
  localparam int CP_RET_WL    = 16;
  localparam int CP_MAX_STEPS = 500;
  localparam int CP_TIMEOUT   = 1024;

  // Start-of-episode state fields, FP32 each, packed {x, x_dot, theta, theta_dot}.
  localparam logic [31:0] CP_INIT_X         = 32'hBDDA4B6F;
  localparam logic [31:0] CP_INIT_X_DOT     = 32'hBE7002B9;
  localparam logic [31:0] CP_INIT_THETA     = 32'h3E53E72E;
  localparam logic [31:0] CP_INIT_THETA_DOT = 32'h3F5F1AFC;

  localparam logic [CP_STA_WL-1:0] CP_INIT_STA =
    {CP_INIT_X, CP_INIT_X_DOT, CP_INIT_THETA, CP_INIT_THETA_DOT};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OBS,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK,
    ST_REPORT
  } ep_state_t;

endpackage

// File: rtl/cartpole_episode_driver_ep_stats.sv
// Per-episode statistics: step counter capped at MAX_STEPS and a
// saturating reward accumulator, both cleared at episode boundaries.
module cartpole_ep_stats #(
  parameter int STEP_WL   = 16,
  parameter int RET_WL    = 16,
  parameter int RWD_WL    = 1,
  parameter int MAX_STEPS = 500
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_inc,
  input  logic [RWD_WL-1:0]  i_rwd,
  output logic [STEP_WL-1:0] o_step,
  output logic [RET_WL-1:0]  o_ret,
  output logic               o_at_limit
);

  // One extra bit over the wider operand so an overflow of the return is visible.
  localparam int SUM_WL = ((RET_WL > RWD_WL) ? RET_WL : RWD_WL) + 1;
  localparam logic [SUM_WL-1:0] RET_MAX = SUM_WL'({RET_WL{1'b1}});

  logic [STEP_WL-1:0] r_step;
  logic [RET_WL-1:0]  r_ret;
  logic [SUM_WL-1:0]  w_sum;
  logic               w_at_limit;

  assign w_sum      = SUM_WL'(r_ret) + SUM_WL'(i_rwd);
  assign w_at_limit = (r_step == STEP_WL'(MAX_STEPS));

  // Count steps and accumulate reward; the step count never passes the limit
  // and the return sticks at all-ones instead of wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_step <= '0;
      r_ret  <= '0;
    end else if (i_clr) begin
      r_step <= '0;
      r_ret  <= '0;
    end else if (i_inc) begin
      if (!w_at_limit) begin
        r_step <= r_step + STEP_WL'(1);
      end
      if (w_sum > RET_MAX) begin
        r_ret <= {RET_WL{1'b1}};
      end else begin
        r_ret <= w_sum[RET_WL-1:0];
      end
    end
  end

  assign o_step     = r_step;
  assign o_ret      = r_ret;
  assign o_at_limit = w_at_limit;

endmodule

// File: rtl/cartpole_episode_driver.sv
// Agent-side episode driver: holds the CartPole state, trades observations for
// policy actions, runs one core step per action and reports each episode.
module cartpole_episode_driver
  import cartpole_episode_driver_pkg::*;
#(
  parameter int STA_WL    = CP_STA_WL,
  parameter int ACT_WL    = CP_ACT_WL,
  parameter int RWD_WL    = CP_RWD_WL,
  parameter int STEP_WL   = CP_STEP_WL,
  parameter int RET_WL    = CP_RET_WL,
  parameter int MAX_STEPS = CP_MAX_STEPS,
  parameter int TIMEOUT   = CP_TIMEOUT,
  parameter logic [STA_WL-1:0] INIT_STA = CP_INIT_STA
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_run,
  output logic [STA_WL-1:0]  o_obs,
  output logic               o_act_ready,
  input  logic               i_act_valid,
  input  logic [ACT_WL-1:0]  i_act,
  output logic               o_env_ena,
  output logic [STA_WL-1:0]  o_env_sta,
  output logic [ACT_WL-1:0]  o_env_act,
  input  logic [STA_WL-1:0]  i_env_sta,
  input  logic [RWD_WL-1:0]  i_env_rwd,
  input  logic               i_env_done,
  input  logic               i_env_valid,
  output logic               o_ep_valid,
  output logic [STEP_WL-1:0] o_ep_len,
  output logic [RET_WL-1:0]  o_ep_ret,
  output logic               o_ep_trunc,
  output logic               o_busy,
  output logic               o_err
);

  localparam int TMO_WL = $clog2(TIMEOUT) + 1;

  ep_state_t          r_state;
  ep_state_t          w_next;
  logic [STA_WL-1:0]  r_sta;
  logic [ACT_WL-1:0]  r_act;
  logic               r_done;
  logic [TMO_WL-1:0]  r_tmo;
  logic               r_err;
  logic [STEP_WL-1:0] r_ep_len;
  logic [RET_WL-1:0]  r_ep_ret;
  logic               r_ep_trunc;

  logic               w_act_ready;
  logic               w_env_ena;
  logic               w_ep_valid;
  logic               w_start;
  logic               w_clr;
  logic               w_accept;
  logic               w_take;
  logic               w_timeout;
  logic               w_summ;
  logic [STEP_WL-1:0] w_step;
  logic [RET_WL-1:0]  w_ret;
  logic               w_at_limit;

  cartpole_ep_stats #(
    .STEP_WL  (STEP_WL),
    .RET_WL   (RET_WL),
    .RWD_WL   (RWD_WL),
    .MAX_STEPS(MAX_STEPS)
  ) u_stats (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_clr),
    .i_inc     (w_take),
    .i_rwd     (i_env_rwd),
    .o_step    (w_step),
    .o_ret     (w_ret),
    .o_at_limit(w_at_limit)
  );

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-state strobes; a core valid is only honoured in WAIT,
  // and a terminal step wins over the step limit when both happen together.
  always_comb begin
    w_next      = r_state;
    w_act_ready = 1'b0;
    w_env_ena   = 1'b0;
    w_ep_valid  = 1'b0;
    w_start     = 1'b0;
    w_clr       = 1'b0;
    w_accept    = 1'b0;
    w_take      = 1'b0;
    w_timeout   = 1'b0;
    w_summ      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_run) begin
          w_next  = ST_OBS;
          w_start = 1'b1;
          w_clr   = 1'b1;
        end
      end
      ST_OBS: begin
        w_act_ready = 1'b1;
        if (i_act_valid) begin
          w_accept = 1'b1;
          w_next   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_env_ena = 1'b1;
        w_next    = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_env_valid) begin
          w_take = 1'b1;
          w_next = ST_CHECK;
        end else if (r_tmo == TMO_WL'(TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (r_done || w_at_limit) begin
          w_summ = 1'b1;
          w_next = ST_REPORT;
        end else begin
          w_next = ST_OBS;
        end
      end
      ST_REPORT: begin
        w_ep_valid = 1'b1;
        w_clr      = 1'b1;
        w_next     = i_run ? ST_OBS : ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Environment state: back to the initial state at every episode boundary,
  // otherwise follows whatever the core returned for the last step.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sta <= INIT_STA;
    end else if (w_clr) begin
      r_sta <= INIT_STA;
    end else if (w_take) begin
      r_sta <= i_env_sta;
    end
  end

  // Hold the accepted action for the core and the terminal flag for CHECK.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_act  <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_accept) begin
        r_act <= i_act;
      end
      if (w_take) begin
        r_done <= i_env_done;
      end
    end
  end

  // Watchdog on the core: restarted by each step request, counts WAIT cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmo <= '0;
    end else if (w_env_ena) begin
      r_tmo <= '0;
    end else if (r_state == ST_WAIT) begin
      r_tmo <= r_tmo + TMO_WL'(1);
    end
  end

  // Sticky timeout error, cleared only when a new run starts from IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (w_start) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  // Episode summary captured on the way into REPORT and held until the next one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ep_len   <= '0;
      r_ep_ret   <= '0;
      r_ep_trunc <= 1'b0;
    end else if (w_summ) begin
      r_ep_len   <= w_step;
      r_ep_ret   <= w_ret;
      r_ep_trunc <= ~r_done;
    end
  end

  assign o_obs       = r_sta;
  assign o_env_sta   = r_sta;
  assign o_env_act   = r_act;
  assign o_act_ready = w_act_ready;
  assign o_env_ena   = w_env_ena;
  assign o_ep_valid  = w_ep_valid;
  assign o_ep_len    = r_ep_len;
  assign o_ep_ret    = r_ep_ret;
  assign o_ep_trunc  = r_ep_trunc;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_err       = r_err;

endmodule
